i2c_target_regs: RTL and testbench

- I2C target (slave) responder. It is the far-end counterpart of the I2C master/command block used by the controller side.
- Decodes START, STOP, address, pointer and data on filtered SCL/SDA. ACKs its own 7-bit address and drives SDA open-drain.
- Exposes a byte-wide register-access port (8-bit pointer, auto-increment), so an on-board register bank can be read and written by an external I2C master.
- Sits between the board I2C pins and a local register file; no clock stretching.

---
 rtl/i2c_target_regs.sv | 203 ++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target responder with an 8-bit auto-incrementing register pointer.
// Filters SCL/SDA, decodes START/STOP/address/data, drives SDA open-drain.
module i2c_target_regs #(
  parameter logic [6:0]  DEVICE_ADDR = 7'h50,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       stop_det
);

  localparam logic [2:0] FiltMax = 3'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StWrPtr, StWrData, StWrAck, StRdData, StRdAck, StIgnore
  } state_e;

  logic [1:0] r_scl_sync, r_sda_sync;
  logic [2:0] r_scl_cnt, r_sda_cnt;
  logic       r_scl_f, r_sda_f, r_scl_q, r_sda_q;
  state_e     r_state;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_ptr;
  logic       r_rw;
  logic       r_data_byte;

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_match;

  // Filtered level follows the synchronized pin only after FILTER_LEN equal samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_cnt  <= '0;
      r_sda_cnt  <= '0;
      r_scl_f    <= 1'b1;
      r_sda_f    <= 1'b1;
      r_scl_q    <= 1'b1;
      r_sda_q    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_i};
      r_sda_sync <= {r_sda_sync[0], sda_i};
      r_scl_q    <= r_scl_f;
      r_sda_q    <= r_sda_f;
      if (r_scl_sync[1] == r_scl_f) begin
        r_scl_cnt <= '0;
      end else if (r_scl_cnt == FiltMax) begin
        r_scl_f   <= r_scl_sync[1];
        r_scl_cnt <= '0;
      end else begin
        r_scl_cnt <= r_scl_cnt + 3'd1;
      end
      if (r_sda_sync[1] == r_sda_f) begin
        r_sda_cnt <= '0;
      end else if (r_sda_cnt == FiltMax) begin
        r_sda_f   <= r_sda_sync[1];
        r_sda_cnt <= '0;
      end else begin
        r_sda_cnt <= r_sda_cnt + 3'd1;
      end
    end
  end

  assign w_scl_rise = r_scl_f & ~r_scl_q;
  assign w_scl_fall = ~r_scl_f & r_scl_q;
  assign w_start    = r_scl_f & r_scl_q & r_sda_q & ~r_sda_f;
  assign w_stop     = r_scl_f & r_scl_q & ~r_sda_q & r_sda_f;
  assign w_match    = (r_shift[7:1] == DEVICE_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_rw        <= 1'b0;
      r_data_byte <= 1'b0;
      sda_oe      <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_wr      <= 1'b0;
      reg_rd      <= 1'b0;
      busy        <= 1'b0;
      stop_det    <= 1'b0;
    end else begin
      reg_wr   <= 1'b0;
      reg_rd   <= 1'b0;
      stop_det <= 1'b0;
      // Read data is captured the cycle after the strobe; no SCL edge can coincide.
      if (reg_rd) r_shift <= reg_rdata;

      if (w_stop) begin
        r_state  <= StIdle;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        stop_det <= 1'b1;
      end else if (w_start) begin
        r_state   <= StAddr;
        r_bit_cnt <= '0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (r_state)
          StAddr, StWrPtr, StWrData: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], r_sda_f};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_bit_cnt <= '0;
              if (r_state == StAddr) begin
                if (w_match) begin
                  sda_oe  <= 1'b1;
                  busy    <= 1'b1;
                  r_rw    <= r_shift[0];
                  r_state <= StAddrAck;
                  if (r_shift[0]) begin
                    reg_rd   <= 1'b1;
                    reg_addr <= r_ptr;
                  end
                end else begin
                  r_state <= StIgnore;
                end
              end else if (r_state == StWrPtr) begin
                r_ptr       <= r_shift;
                r_data_byte <= 1'b0;
                sda_oe      <= 1'b1;
                r_state     <= StWrAck;
              end else begin
                reg_wdata   <= r_shift;
                reg_addr    <= r_ptr;
                reg_wr      <= 1'b1;
                r_data_byte <= 1'b1;
                sda_oe      <= 1'b1;
                r_state     <= StWrAck;
              end
            end
          end
          StAddrAck: begin
            if (w_scl_fall) begin
              if (r_rw) begin
                sda_oe    <= ~r_shift[7];
                r_shift   <= {r_shift[6:0], 1'b0};
                r_bit_cnt <= 4'd1;
                r_state   <= StRdData;
              end else begin
                sda_oe    <= 1'b0;
                r_bit_cnt <= '0;
                r_state   <= StWrPtr;
              end
            end
          end
          StWrAck: begin
            if (w_scl_fall) begin
              sda_oe    <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= StWrData;
              if (r_data_byte) r_ptr <= r_ptr + 8'd1;
            end
          end
          StRdData: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                sda_oe    <= 1'b0;
                r_bit_cnt <= '0;
                r_state   <= StRdAck;
              end else begin
                sda_oe    <= ~r_shift[7];
                r_shift   <= {r_shift[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          StRdAck: begin
            if (w_scl_rise) begin
              if (!r_sda_f) begin
                r_ptr    <= r_ptr + 8'd1;
                reg_addr <= r_ptr + 8'd1;
                reg_rd   <= 1'b1;
                r_state  <= StRdData;
              end else begin
                busy    <= 1'b0;
                r_state <= StIgnore;
              end
            end
          end
          StIdle, StIgnore: ;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged I2C master plus a strobe monitor.
module tb_i2c_target_regs;

  localparam int Q = 10;  // clocks per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr, reg_rd, busy, stop_det;

  int n_tests = 0;
  int n_fail = 0;

  int wr_n = 0, rd_n = 0, stop_n = 0, oe_n = 0, both_n = 0;
  logic [7:0] wr_a [16];
  logic [7:0] wr_d [16];
  logic [7:0] rd_a [16];

  always #5 clk = ~clk;

  assign sda_line  = sda_m & ~sda_oe;
  assign reg_rdata = reg_addr ^ 8'h5A;

  i2c_target_regs #(.DEVICE_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .stop_det  (stop_det)
  );

  always @(posedge clk) begin
    if (reg_wr) begin
      if (wr_n < 16) begin
        wr_a[wr_n] <= reg_addr;
        wr_d[wr_n] <= reg_wdata;
      end
      wr_n <= wr_n + 1;
    end
    if (reg_rd) begin
      if (rd_n < 16) rd_a[rd_n] <= reg_addr;
      rd_n <= rd_n + 1;
    end
    if (stop_det) stop_n <= stop_n + 1;
    if (sda_oe) oe_n <= oe_n + 1;
    if (reg_wr && reg_rd) both_n <= both_n + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL clock; optional 1-clk SCL glitch in the low phase; samples SDA mid-high.
  task automatic clk_bit(input logic b, input logic glitch, output logic smp);
    sda_m = b;
    if (glitch) begin
      tick(4);
      scl = 1'b1;
      tick(1);
      scl = 1'b0;
      tick(Q - 5);
    end else begin
      tick(Q);
    end
    scl = 1'b1;
    tick(Q);
    smp = sda_line;
    tick(Q);
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    sda_m = 1'b0;
    tick(Q);
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    sda_m = 1'b1;
    tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], (i == glitch_bit), s);
    clk_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    clk_bit(nack, 1'b0, s);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] d;
    int         w0, r0, st0, oe0;

    tick(4);
    check_eq("rst sda_oe", sda_oe, 0);
    check_eq("rst reg_addr", reg_addr, 0);
    check_eq("rst reg_wdata", reg_wdata, 0);
    check_eq("rst reg_wr", reg_wr, 0);
    check_eq("rst reg_rd", reg_rd, 0);
    check_eq("rst busy", busy, 0);
    check_eq("rst stop_det", stop_det, 0);
    rst_n = 1'b1;
    tick(Q);

    // Write pointer 0x10, data 0x11, 0x22
    w0 = wr_n; st0 = stop_n;
    i2c_start();
    wr_byte(8'hA0, -1, ack); check_eq("w addr ack", ack, 1);
    check_eq("w busy", busy, 1);
    wr_byte(8'h10, -1, ack); check_eq("w ptr ack", ack, 1);
    wr_byte(8'h11, -1, ack); check_eq("w d0 ack", ack, 1);
    wr_byte(8'h22, -1, ack); check_eq("w d1 ack", ack, 1);
    i2c_stop();
    tick(Q);
    check_eq("w count", wr_n - w0, 2);
    check_eq("w0 addr", wr_a[w0], 8'h10);
    check_eq("w0 data", wr_d[w0], 8'h11);
    check_eq("w1 addr", wr_a[w0+1], 8'h11);
    check_eq("w1 data", wr_d[w0+1], 8'h22);
    check_eq("w stop_det", stop_n - st0, 1);
    check_eq("w busy end", busy, 0);

    // Pointer 0x10, repeated START, read 3 bytes
    r0 = rd_n;
    i2c_start();
    wr_byte(8'hA0, -1, ack); check_eq("r waddr ack", ack, 1);
    wr_byte(8'h10, -1, ack); check_eq("r ptr ack", ack, 1);
    i2c_start();
    wr_byte(8'hA1, -1, ack); check_eq("r raddr ack", ack, 1);
    rd_byte(1'b0, d); check_eq("r byte0", d, 8'h4A);
    rd_byte(1'b0, d); check_eq("r byte1", d, 8'h4B);
    rd_byte(1'b1, d); check_eq("r byte2", d, 8'h48);
    check_eq("r busy after nack", busy, 0);
    i2c_stop();
    tick(Q);
    check_eq("r rd count", rd_n - r0, 3);
    check_eq("r rd0 addr", rd_a[r0], 8'h10);
    check_eq("r rd1 addr", rd_a[r0+1], 8'h11);
    check_eq("r rd2 addr", rd_a[r0+2], 8'h12);

    // Foreign address 0x51
    w0 = wr_n; r0 = rd_n; st0 = stop_n; oe0 = oe_n;
    i2c_start();
    wr_byte(8'hA2, -1, ack); check_eq("nack addr", ack, 0);
    check_eq("nack busy", busy, 0);
    wr_byte(8'h33, -1, ack); check_eq("nack data", ack, 0);
    i2c_stop();
    tick(Q);
    check_eq("nack oe cycles", oe_n - oe0, 0);
    check_eq("nack writes", wr_n - w0, 0);
    check_eq("nack reads", rd_n - r0, 0);
    check_eq("nack stop_det", stop_n - st0, 1);

    // Pointer wrap 0xFE..0x00
    w0 = wr_n;
    i2c_start();
    wr_byte(8'hA0, -1, ack); check_eq("wrap addr ack", ack, 1);
    wr_byte(8'hFE, -1, ack);
    wr_byte(8'h01, -1, ack);
    wr_byte(8'h02, -1, ack);
    wr_byte(8'h03, -1, ack); check_eq("wrap d2 ack", ack, 1);
    i2c_stop();
    tick(Q);
    check_eq("wrap count", wr_n - w0, 3);
    check_eq("wrap a0", wr_a[w0], 8'hFE);
    check_eq("wrap a1", wr_a[w0+1], 8'hFF);
    check_eq("wrap a2", wr_a[w0+2], 8'h00);
    check_eq("wrap d2", wr_d[w0+2], 8'h03);

    // STOP after 4 bits of a data byte, then read from the retained pointer
    w0 = wr_n; r0 = rd_n;
    i2c_start();
    wr_byte(8'hA0, -1, ack);
    wr_byte(8'h20, -1, ack); check_eq("part ptr ack", ack, 1);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, 1'b0, s);
    i2c_stop();
    tick(Q);
    check_eq("part no write", wr_n - w0, 0);
    i2c_start();
    wr_byte(8'hA1, -1, ack); check_eq("part raddr ack", ack, 1);
    rd_byte(1'b1, d); check_eq("part rdata", d, 8'h7A);
    i2c_stop();
    tick(Q);
    check_eq("part rd addr", rd_a[r0], 8'h20);

    // SCL glitch during a data byte
    w0 = wr_n;
    i2c_start();
    wr_byte(8'hA0, -1, ack);
    wr_byte(8'h30, -1, ack);
    wr_byte(8'h5C, 3, ack); check_eq("glitch ack", ack, 1);
    i2c_stop();
    tick(Q);
    check_eq("glitch count", wr_n - w0, 1);
    check_eq("glitch addr", wr_a[w0], 8'h30);
    check_eq("glitch data", wr_d[w0], 8'h5C);

    // Async reset while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) clk_bit(((8'hA0 >> i) & 8'h01) != 0, 1'b0, s);
    check_eq("pre-rst sda_oe", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check_eq("async rst sda_oe", sda_oe, 0);
    check_eq("async rst busy", busy, 0);
    sda_m = 1'b1;
    scl = 1'b1;
    tick(Q);
    rst_n = 1'b1;
    tick(Q);
    check_eq("post-rst reg_addr", reg_addr, 0);
    check_eq("never wr&rd", both_n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
